gfx_mem_arbiter: RTL and testbench

- Shares the DDR2 request FIFOs (address FIFO `af_*`, write-data FIFO `wdf_*`) between two graphics write requesters: the line engine (`le_*`) and the rectangle fill engine (`fe_*`).
- Each requester hands over one complete burst-write transaction. The arbiter emits it as one address-FIFO entry plus two consecutive 128-bit write-data words, never interleaving two transactions.
- Sits between the graphics engines and the memory-controller FIFOs.

---
 rtl/gfx_mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_gfx_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gfx_mem_arbiter.sv
// gfx_mem_arbiter
//   Shares the DDR2 address FIFO (af_*) and write-data FIFO (wdf_*) between
//   the line engine (le_*) and the rectangle fill engine (fe_*). A granted
//   transaction is emitted as one address entry plus two consecutive
//   128-bit data words. Transactions are never interleaved.
//
// State table:
//   IDLE | no transaction held; grant given to a valid requester
//   WR0  | push address + data word 0 (both FIFOs must have room)
//   WR1  | push data word 1 (only the data FIFO must have room)
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   le_valid/addr/data/mask  line engine transaction (data[127:0] first word)
//   le_ready                 line engine transaction accepted this cycle
//   fe_*                     same for the fill engine
//   af_full, wdf_full        FIFO full flags
//   af_cmd_din/addr_din/wr_en  address FIFO write port (cmd always write)
//   wdf_din/mask_din/wr_en     write-data FIFO write port
//   arb_busy                 a transaction is held (not IDLE)
//   last_grant               0 = line engine granted last, 1 = fill engine
module gfx_mem_arbiter #(
    parameter int FIXED_PRIO = 0,
    parameter int ADDR_W     = 31
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              le_valid,
    input  logic [ADDR_W-1:0] le_addr,
    input  logic [255:0]      le_data,
    input  logic [31:0]       le_mask,
    output logic              le_ready,
    input  logic              fe_valid,
    input  logic [ADDR_W-1:0] fe_addr,
    input  logic [255:0]      fe_data,
    input  logic [31:0]       fe_mask,
    output logic              fe_ready,
    input  logic              af_full,
    input  logic              wdf_full,
    output logic [2:0]        af_cmd_din,
    output logic [ADDR_W-1:0] af_addr_din,
    output logic              af_wr_en,
    output logic [127:0]      wdf_din,
    output logic [15:0]       wdf_mask_din,
    output logic              wdf_wr_en,
    output logic              arb_busy,
    output logic              last_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_t;

    state_t            state_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic [127:0]      din_q;
    logic [15:0]       mask_q;
    logic [127:0]      data_hi_q;
    logic [15:0]       mask_hi_q;

    logic gnt_le;
    logic gnt_fe;
    logic in_idle;
    logic push0;
    logic push1;

    // Round-robin favours the requester that did not win last time;
    // a lone requester always wins.
    always_comb begin
        gnt_le = 1'b0;
        gnt_fe = 1'b0;
        if (le_valid && fe_valid) begin
            if ((FIXED_PRIO != 0) || last_grant_q) begin
                gnt_le = 1'b1;
            end else begin
                gnt_fe = 1'b1;
            end
        end else begin
            gnt_le = le_valid;
            gnt_fe = fe_valid;
        end
    end

    assign in_idle = (state_q == IDLE);
    // Address and first word go out together or not at all.
    assign push0   = (state_q == WR0) && !af_full && !wdf_full;
    assign push1   = (state_q == WR1) && !wdf_full;

    // Handshake and push strobes are gated by rst so they drop the moment
    // reset asserts, independent of the clock.
    assign le_ready     = rst & in_idle & gnt_le;
    assign fe_ready     = rst & in_idle & gnt_fe;
    assign af_wr_en     = rst & push0;
    assign wdf_wr_en    = rst & (push0 | push1);
    assign arb_busy     = rst & !in_idle;
    assign last_grant   = last_grant_q;
    assign af_cmd_din   = 3'b000;
    assign af_addr_din  = addr_q;
    assign wdf_din      = din_q;
    assign wdf_mask_din = mask_q;

    // din_q/mask_q carry word 0 through WR0 and are reloaded with word 1 on
    // the WR0 push, so the data bus keeps its last driven value in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            din_q        <= '0;
            mask_q       <= '0;
            data_hi_q    <= '0;
            mask_hi_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt_le) begin
                        addr_q       <= le_addr;
                        din_q        <= le_data[127:0];
                        mask_q       <= le_mask[15:0];
                        data_hi_q    <= le_data[255:128];
                        mask_hi_q    <= le_mask[31:16];
                        last_grant_q <= 1'b0;
                        state_q      <= WR0;
                    end else if (gnt_fe) begin
                        addr_q       <= fe_addr;
                        din_q        <= fe_data[127:0];
                        mask_q       <= fe_mask[15:0];
                        data_hi_q    <= fe_data[255:128];
                        mask_hi_q    <= fe_mask[31:16];
                        last_grant_q <= 1'b1;
                        state_q      <= WR0;
                    end
                end
                WR0: begin
                    if (push0) begin
                        din_q   <= data_hi_q;
                        mask_q  <= mask_hi_q;
                        state_q <= WR1;
                    end
                end
                WR1: begin
                    if (push1) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gfx_mem_arbiter.sv
module tb_gfx_mem_arbiter;

    localparam logic [30:0]  LA = 31'h0040_0010;
    localparam logic [30:0]  FA = 31'h0012_3400;
    localparam logic [127:0] WA = 128'hA;
    localparam logic [127:0] WB = 128'hB;
    localparam logic [127:0] WC = 128'hC;
    localparam logic [127:0] WD = 128'hD;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic le_valid = 1'b0, fe_valid = 1'b0;
    logic le_valid1 = 1'b0, fe_valid1 = 1'b0;
    logic [30:0]  le_addr = LA, fe_addr = FA;
    logic [255:0] le_data = {WB, WA};
    logic [255:0] fe_data = {WD, WC};
    logic [31:0]  le_mask = 32'h0000_FFF0;
    logic [31:0]  fe_mask = 32'hFFFF_FFFF;
    logic af_full = 1'b0, wdf_full = 1'b0;

    logic le_ready, fe_ready, af_wr_en, wdf_wr_en, arb_busy, last_grant;
    logic [2:0]   af_cmd_din;
    logic [30:0]  af_addr_din;
    logic [127:0] wdf_din;
    logic [15:0]  wdf_mask_din;

    logic le_ready1, fe_ready1, af_wr_en1, wdf_wr_en1, arb_busy1, last_grant1;
    logic [2:0]   af_cmd_din1;
    logic [30:0]  af_addr_din1;
    logic [127:0] wdf_din1;
    logic [15:0]  wdf_mask_din1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    gfx_mem_arbiter #(.FIXED_PRIO(0), .ADDR_W(31)) dut (
        .clk(clk), .rst(rst),
        .le_valid(le_valid), .le_addr(le_addr), .le_data(le_data), .le_mask(le_mask), .le_ready(le_ready),
        .fe_valid(fe_valid), .fe_addr(fe_addr), .fe_data(fe_data), .fe_mask(fe_mask), .fe_ready(fe_ready),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_cmd_din(af_cmd_din), .af_addr_din(af_addr_din), .af_wr_en(af_wr_en),
        .wdf_din(wdf_din), .wdf_mask_din(wdf_mask_din), .wdf_wr_en(wdf_wr_en),
        .arb_busy(arb_busy), .last_grant(last_grant)
    );

    gfx_mem_arbiter #(.FIXED_PRIO(1), .ADDR_W(31)) dut_fp (
        .clk(clk), .rst(rst),
        .le_valid(le_valid1), .le_addr(le_addr), .le_data(le_data), .le_mask(le_mask), .le_ready(le_ready1),
        .fe_valid(fe_valid1), .fe_addr(fe_addr), .fe_data(fe_data), .fe_mask(fe_mask), .fe_ready(fe_ready1),
        .af_full(af_full), .wdf_full(wdf_full),
        .af_cmd_din(af_cmd_din1), .af_addr_din(af_addr_din1), .af_wr_en(af_wr_en1),
        .wdf_din(wdf_din1), .wdf_mask_din(wdf_mask_din1), .wdf_wr_en(wdf_wr_en1),
        .arb_busy(arb_busy1), .last_grant(last_grant1)
    );

    typedef struct {
        logic         rb, lv, fv, aff, wff;
        logic         lr, fr, af, wd, busy, lg;
        logic [30:0]  addr;
        logic [127:0] din;
        logic [15:0]  msk;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic rb, lv, fv, aff, wff,
                                input logic lr, fr, af, wd, busy, lg,
                                input logic [30:0] addr, input logic [127:0] din,
                                input logic [15:0] msk);
        vec_t v;
        v.rb = rb; v.lv = lv; v.fv = fv; v.aff = aff; v.wff = wff;
        v.lr = lr; v.fr = fr; v.af = af; v.wd = wd; v.busy = busy; v.lg = lg;
        v.addr = addr; v.din = din; v.msk = msk;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    int n_af, n_wd;

    initial begin
        // rb lv fv aff wff | lr fr af wd busy lg | addr din mask
        // single line-engine write
        vt.push_back(mk(1,1,0,0,0, 1,0,0,0,0,1, 31'h0, 128'h0, 16'h0000));
        vt.push_back(mk(1,0,0,0,0, 0,0,1,1,1,0, LA, WA, 16'hFFF0));
        vt.push_back(mk(1,0,0,0,0, 0,0,0,1,1,0, LA, WB, 16'h0000));
        vt.push_back(mk(1,0,0,0,0, 0,0,0,0,0,0, LA, WB, 16'h0000));
        // reset, then round-robin contention for 4 transactions
        vt.push_back(mk(0,1,1,0,0, 0,0,0,0,0,1, 31'h0, 128'h0, 16'h0000));
        vt.push_back(mk(1,1,1,0,0, 1,0,0,0,0,1, 31'h0, 128'h0, 16'h0000));
        vt.push_back(mk(1,1,1,0,0, 0,0,1,1,1,0, LA, WA, 16'hFFF0));
        vt.push_back(mk(1,1,1,0,0, 0,0,0,1,1,0, LA, WB, 16'h0000));
        vt.push_back(mk(1,1,1,0,0, 0,1,0,0,0,0, LA, WB, 16'h0000));
        vt.push_back(mk(1,1,1,0,0, 0,0,1,1,1,1, FA, WC, 16'hFFFF));
        vt.push_back(mk(1,1,1,0,0, 0,0,0,1,1,1, FA, WD, 16'hFFFF));
        vt.push_back(mk(1,1,1,0,0, 1,0,0,0,0,1, FA, WD, 16'hFFFF));
        vt.push_back(mk(1,1,1,0,0, 0,0,1,1,1,0, LA, WA, 16'hFFF0));
        vt.push_back(mk(1,1,1,0,0, 0,0,0,1,1,0, LA, WB, 16'h0000));
        vt.push_back(mk(1,1,1,0,0, 0,1,0,0,0,0, LA, WB, 16'h0000));
        vt.push_back(mk(1,0,0,0,0, 0,0,1,1,1,1, FA, WC, 16'hFFFF));
        vt.push_back(mk(1,0,0,0,0, 0,0,0,1,1,1, FA, WD, 16'hFFFF));
        vt.push_back(mk(1,0,0,0,0, 0,0,0,0,0,1, FA, WD, 16'hFFFF));
        // lone fill request wins even though it was granted last
        vt.push_back(mk(1,0,1,0,0, 0,1,0,0,0,1, FA, WD, 16'hFFFF));
        vt.push_back(mk(1,0,0,0,0, 0,0,1,1,1,1, FA, WC, 16'hFFFF));
        vt.push_back(mk(1,0,0,0,0, 0,0,0,1,1,1, FA, WD, 16'hFFFF));
        vt.push_back(mk(1,0,0,0,0, 0,0,0,0,0,1, FA, WD, 16'hFFFF));

        repeat (3) @(negedge clk);
        #1;
        chk("reset le_ready", {127'h0, le_ready}, 128'h0);
        chk("reset last_grant", {127'h0, last_grant}, 128'h1);
        chk("reset af_addr_din", {97'h0, af_addr_din}, 128'h0);
        chk("reset af_cmd_din", {125'h0, af_cmd_din}, 128'h0);

        foreach (vt[i]) begin
            @(negedge clk);
            rst = vt[i].rb; le_valid = vt[i].lv; fe_valid = vt[i].fv;
            af_full = vt[i].aff; wdf_full = vt[i].wff;
            #1;
            chk($sformatf("v%0d le_ready", i), {127'h0, le_ready}, {127'h0, vt[i].lr});
            chk($sformatf("v%0d fe_ready", i), {127'h0, fe_ready}, {127'h0, vt[i].fr});
            chk($sformatf("v%0d af_wr_en", i), {127'h0, af_wr_en}, {127'h0, vt[i].af});
            chk($sformatf("v%0d wdf_wr_en", i), {127'h0, wdf_wr_en}, {127'h0, vt[i].wd});
            chk($sformatf("v%0d arb_busy", i), {127'h0, arb_busy}, {127'h0, vt[i].busy});
            chk($sformatf("v%0d last_grant", i), {127'h0, last_grant}, {127'h0, vt[i].lg});
            chk($sformatf("v%0d af_addr_din", i), {97'h0, af_addr_din}, {97'h0, vt[i].addr});
            chk($sformatf("v%0d wdf_din", i), wdf_din, vt[i].din);
            chk($sformatf("v%0d wdf_mask_din", i), {112'h0, wdf_mask_din}, {112'h0, vt[i].msk});
        end

        // af_full stall for 5 cycles in WR0 (idle, last_grant=1)
        @(negedge clk);
        le_valid = 1; fe_valid = 0; af_full = 1; wdf_full = 0;
        #1 chk("afstall accept", {127'h0, le_ready}, 128'h1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            le_valid = 0;
            #1;
            chk($sformatf("afstall c%0d af_wr_en", c), {127'h0, af_wr_en}, 128'h0);
            chk($sformatf("afstall c%0d wdf_wr_en", c), {127'h0, wdf_wr_en}, 128'h0);
            chk($sformatf("afstall c%0d busy", c), {127'h0, arb_busy}, 128'h1);
        end
        n_af = 0; n_wd = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            af_full = 0;
            #1;
            n_af += int'(af_wr_en);
            n_wd += int'(wdf_wr_en);
        end
        chk("afstall addr pushes", 128'(n_af), 128'd1);
        chk("afstall data pushes", 128'(n_wd), 128'd2);
        chk("afstall idle after", {127'h0, arb_busy}, 128'h0);

        // wdf_full stall in WR1 for 3 cycles; af_full high in WR1 is ignored
        @(negedge clk);
        le_valid = 1;
        #1 chk("wdfstall accept", {127'h0, le_ready}, 128'h1);
        @(negedge clk);
        le_valid = 0;
        #1 chk("wdfstall wr0 push", {126'h0, af_wr_en, wdf_wr_en}, 128'h3);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            wdf_full = 1;
            #1;
            chk($sformatf("wdfstall c%0d wdf_wr_en", c), {127'h0, wdf_wr_en}, 128'h0);
            chk($sformatf("wdfstall c%0d af_wr_en", c), {127'h0, af_wr_en}, 128'h0);
            chk($sformatf("wdfstall c%0d wdf_din", c), wdf_din, WB);
        end
        @(negedge clk);
        wdf_full = 0; af_full = 1;
        #1;
        chk("wdfstall release wdf_wr_en", {127'h0, wdf_wr_en}, 128'h1);
        chk("wdfstall release af_wr_en", {127'h0, af_wr_en}, 128'h0);
        @(negedge clk);
        af_full = 0;
        #1;
        chk("wdfstall done wr_en", {126'h0, af_wr_en, wdf_wr_en}, 128'h0);
        chk("wdfstall done busy", {127'h0, arb_busy}, 128'h0);

        // reset in WR1: strobes, busy and ready drop asynchronously
        @(negedge clk);
        le_valid = 1;
        #1 chk("rstmid accept", {127'h0, le_ready}, 128'h1);
        @(negedge clk);
        le_valid = 0;
        @(negedge clk);
        wdf_full = 1;
        #1 chk("rstmid wr1 stalled", {127'h0, wdf_wr_en}, 128'h0);
        @(negedge clk);
        wdf_full = 0; le_valid = 1;
        #1 chk("rstmid wr1 pushing", {127'h0, wdf_wr_en}, 128'h1);
        #2 rst = 0;
        #1;
        chk("rstmid async wdf_wr_en", {127'h0, wdf_wr_en}, 128'h0);
        chk("rstmid async busy", {127'h0, arb_busy}, 128'h0);
        chk("rstmid async le_ready", {127'h0, le_ready}, 128'h0);
        chk("rstmid async last_grant", {127'h0, last_grant}, 128'h1);
        @(negedge clk);
        rst = 1; le_valid = 0;
        n_af = 0; n_wd = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_af += int'(af_wr_en);
            n_wd += int'(wdf_wr_en);
            chk($sformatf("rstmid after c%0d busy", c), {127'h0, arb_busy}, 128'h0);
            @(negedge clk);
        end
        chk("rstmid stray pushes", 128'(n_af + n_wd), 128'd0);
        chk("rstmid last_grant", {127'h0, last_grant}, 128'h1);

        // fixed priority instance: line engine wins every tie
        for (int t = 0; t < 3; t++) begin
            le_valid1 = 1; fe_valid1 = 1;
            #1;
            chk($sformatf("fp t%0d le_ready", t), {127'h0, le_ready1}, 128'h1);
            chk($sformatf("fp t%0d fe_ready", t), {127'h0, fe_ready1}, 128'h0);
            @(negedge clk);
            #1;
            chk($sformatf("fp t%0d wr0", t), {126'h0, af_wr_en1, fe_ready1}, 128'h2);
            chk($sformatf("fp t%0d wr0 addr", t), {97'h0, af_addr_din1}, {97'h0, LA});
            @(negedge clk);
            #1;
            chk($sformatf("fp t%0d wr1", t), {126'h0, wdf_wr_en1, fe_ready1}, 128'h2);
            @(negedge clk);
        end
        le_valid1 = 0;
        #1;
        chk("fp fe after le drops", {126'h0, fe_ready1, le_ready1}, 128'h2);
        @(negedge clk);
        fe_valid1 = 0;
        #1 chk("fp fe wr0 addr", {97'h0, af_addr_din1}, {97'h0, FA});
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
